// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the WS2812B LED chain: pixel formats,
// feeder FSM encoding and the bit-timing defaults used by ws2812b_out_module.
package ws2812b_pkg;

    localparam int COLOR_W = 8;
    localparam int PIXEL_W = 24;

    // Bit timing in 9 MHz clk cycles (T0H ~0.4 us, T1H ~0.8 us, latch > 50 us)
    localparam int CYCLES_SHORT = 4;
    localparam int CYCLES_LONG  = 7;
    localparam int CYCLES_RET   = 500;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PRESENT
    } feeder_state_t;

    // The LEDs shift in green first, so the host's RGB order is reshuffled
    function automatic logic [PIXEL_W-1:0] rgb_to_grb(input rgb_t px);
        return {px.g, px.r, px.b};
    endfunction

endpackage

// File: rtl/ws2812b_pixel_ram.sv
// Two banks of LEDCOUNT pixels in one array: one write port, one registered
// read port, shaped so the tools map it onto iCE40 EBR.
module ws2812b_pixel_ram
    import ws2812b_pkg::*;
#(
    parameter int LEDCOUNT = 36,
    parameter int ADDR_W   = 6
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic               i_wr_bank,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [PIXEL_W-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic               i_rd_bank,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [PIXEL_W-1:0] o_rd_data
);

    localparam int                MEM_AW     = $clog2(2 * LEDCOUNT);
    localparam logic [MEM_AW-1:0] BANK1_BASE = MEM_AW'(LEDCOUNT);

    logic [PIXEL_W-1:0] r_mem [0:2*LEDCOUNT-1];
    logic [PIXEL_W-1:0] r_rd_data;
    logic [MEM_AW-1:0]  w_wr_idx;
    logic [MEM_AW-1:0]  w_rd_idx;

    assign w_wr_idx  = MEM_AW'(i_wr_addr) + (i_wr_bank ? BANK1_BASE : '0);
    assign w_rd_idx  = MEM_AW'(i_rd_addr) + (i_rd_bank ? BANK1_BASE : '0);
    assign o_rd_data = r_rd_data;

    // NOTE: no reset here; a reset port on the array would stop it mapping to block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[w_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[w_rd_idx];
        end
    end

endmodule

// File: rtl/ws2812b_frame_feeder.sv
// Double-buffered pixel store that, on every frame tick, streams the front
// bank LED by LED as GRB words to the WS2812B bit serialiser.
module ws2812b_frame_feeder
    import ws2812b_pkg::*;
#(
    parameter int LEDCOUNT = 36,
    parameter int ADDR_W   = 6,
    parameter int FPS_DIV  = 90000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               commit,
    output logic               bitstream_available,
    output logic [PIXEL_W-1:0] bitstream,
    input  logic               bitstream_read,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               commit_pending,
    output logic               frame_overrun
);

    localparam int                 TICK_W      = $clog2(FPS_DIV);
    localparam logic [TICK_W-1:0]  TICK_RELOAD = TICK_W'(FPS_DIV - 1);
    localparam int                 LIMIT_W     = ADDR_W + 1;
    localparam logic [LIMIT_W-1:0] LED_LIMIT   = LIMIT_W'(LEDCOUNT);
    localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(LEDCOUNT - 1);

    feeder_state_t      r_state;
    feeder_state_t      w_next_state;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               r_front;
    logic               r_pending;
    logic [ADDR_W-1:0]  r_index;
    logic               r_avail;
    logic [PIXEL_W-1:0] r_bitstream;
    logic               r_busy;
    logic               r_done;
    logic               r_overrun;

    logic               w_tick;
    logic               w_start;
    logic               w_swap;
    logic               w_rd_en;
    logic               w_load;
    logic               w_take;
    logic               w_last;
    logic               w_drop;
    logic               w_wr_en;
    logic [PIXEL_W-1:0] w_rd_data;

    assign w_tick  = (r_tick_cnt == '0);
    assign w_wr_en = wr_en && ({1'b0, wr_addr} < LED_LIMIT);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tick_cnt <= TICK_RELOAD;
        end else if (w_tick) begin
            r_tick_cnt <= TICK_RELOAD;
        end else begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first, so no path through the block leaves a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_tick) w_next_state = ST_FETCH;
            ST_FETCH:   w_next_state = ST_LOAD;
            ST_LOAD:    w_next_state = ST_PRESENT;
            ST_PRESENT: begin
                if (bitstream_read) begin
                    w_next_state = (r_index == LAST_IDX) ? ST_IDLE : ST_FETCH;
                end
            end
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // A commit arriving together with the accepted tick still swaps this frame
    always_comb begin
        w_start = (r_state == ST_IDLE) && w_tick;
        w_swap  = w_start && (r_pending || commit);
        w_rd_en = (r_state == ST_FETCH);
        w_load  = (r_state == ST_LOAD);
        w_take  = (r_state == ST_PRESENT) && bitstream_read;
        w_last  = w_take && (r_index == LAST_IDX);
        w_drop  = w_tick && (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_front     <= 1'b0;
            r_pending   <= 1'b0;
            r_index     <= '0;
            r_avail     <= 1'b0;
            r_bitstream <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done    <= w_last;
            r_overrun <= w_drop;
            r_pending <= w_swap ? 1'b0 : (r_pending | commit);
            if (w_swap) begin
                r_front <= ~r_front;
            end
            if (w_start) begin
                r_index <= '0;
                r_busy  <= 1'b1;
            end else if (w_last) begin
                r_busy  <= 1'b0;
            end else if (w_take) begin
                r_index <= r_index + 1'b1;
            end
            if (w_load) begin
                r_bitstream <= rgb_to_grb(w_rd_data);
                r_avail     <= 1'b1;
            end else if (w_take) begin
                r_avail     <= 1'b0;
            end
        end
    end

    // Host writes always land in the bank not being streamed
    ws2812b_pixel_ram #(
        .LEDCOUNT (LEDCOUNT),
        .ADDR_W   (ADDR_W)
    ) u_pixel_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (~r_front),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (r_front),
        .i_rd_addr (r_index),
        .o_rd_data (w_rd_data)
    );

    assign bitstream_available = r_avail;
    assign bitstream           = r_bitstream;
    assign frame_busy          = r_busy;
    assign frame_done          = r_done;
    assign commit_pending      = r_pending;
    assign frame_overrun       = r_overrun;

endmodule

// File: tb/tb_ws2812b_frame_feeder.sv
// Directed bench for ws2812b_frame_feeder: a latency-level frame model is
// compared with the DUT every cycle, backed by hand-computed word values.
module tb_ws2812b_frame_feeder;

    localparam int LEDCOUNT = 12;
    localparam int ADDR_W   = 6;
    localparam int FPS_DIV  = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              commit;
    logic              bitstream_available;
    logic [23:0]       bitstream;
    logic              bitstream_read;
    logic              frame_busy;
    logic              frame_done;
    logic              commit_pending;
    logic              frame_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    ws2812b_frame_feeder #(
        .LEDCOUNT (LEDCOUNT),
        .ADDR_W   (ADDR_W),
        .FPS_DIV  (FPS_DIV)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .commit              (commit),
        .bitstream_available (bitstream_available),
        .bitstream           (bitstream),
        .bitstream_read      (bitstream_read),
        .frame_busy          (frame_busy),
        .frame_done          (frame_done),
        .commit_pending      (commit_pending),
        .frame_overrun       (frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [23:0] to_grb(input logic [23:0] p);
        return {p[15:8], p[23:16], p[7:0]};
    endfunction

    // Frame model: ticks every FPS_DIV cycles after reset; a word appears three
    // cycles after an accepted tick or a read; done follows the last read.
    logic [23:0] m_mem   [2][LEDCOUNT];
    bit          m_known [2][LEDCOUNT];
    bit          m_valid = 1'b0;
    int          m_n, m_idx, m_wait;
    bit          m_front, m_pending, m_busy, m_avail, m_done, m_overrun, m_word_known;
    logic [23:0] m_word;

    always @(posedge clk) begin
        bit tick;
        bit old_front;
        bit swapped;
        if (!resetn) begin
            m_valid   = 1'b1;
            m_n       = 0;
            m_front   = 1'b0;
            m_pending = 1'b0;
            m_busy    = 1'b0;
            m_avail   = 1'b0;
            m_done    = 1'b0;
            m_overrun = 1'b0;
            m_idx     = 0;
            m_wait    = 0;
        end else if (m_valid) begin
            tick      = (m_n % FPS_DIV) == FPS_DIV - 1;
            m_n++;
            old_front = m_front;
            swapped   = 1'b0;
            m_done    = 1'b0;
            m_overrun = 1'b0;
            if (m_busy) begin
                if (tick) m_overrun = 1'b1;
                if (m_wait > 0) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_avail      = 1'b1;
                        m_word       = to_grb(m_mem[m_front][m_idx]);
                        m_word_known = m_known[m_front][m_idx];
                    end
                end else if (m_avail && bitstream_read) begin
                    m_avail = 1'b0;
                    if (m_idx == LEDCOUNT - 1) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_idx++;
                        m_wait = 2;
                    end
                end
            end else if (tick) begin
                if (m_pending || commit) begin
                    m_front   = ~m_front;
                    m_pending = 1'b0;
                    swapped   = 1'b1;
                end
                m_busy = 1'b1;
                m_idx  = 0;
                m_wait = 2;
            end
            if (commit && !swapped) m_pending = 1'b1;
            if (wr_en && wr_addr < LEDCOUNT) begin
                m_mem[~old_front][wr_addr]   = wr_data;
                m_known[~old_front][wr_addr] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("available", bitstream_available, m_avail);
            check("frame_busy", frame_busy, m_busy);
            check("frame_done", frame_done, m_done);
            check("frame_overrun", frame_overrun, m_overrun);
            check("commit_pending", commit_pending, m_pending);
            if (m_avail && m_word_known) check("bitstream", bitstream, m_word);
        end
    end

    task automatic write_px(input int a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic next_word(output logic [23:0] w);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bitstream_available && k < 200);
        check("word_wait", bitstream_available, 1'b1);
        w = bitstream;
    endtask

    task automatic wait_frame();
        int k = 0;
        while (frame_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        while (!frame_busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("frame_start", frame_busy, 1'b1);
    endtask

    task automatic count_to_done(output int words);
        int k = 0;
        words = 0;
        do begin
            @(negedge clk);
            k++;
            if (bitstream_available) words++;
        end while (!frame_done && k < 300);
        check("done_seen", frame_done, 1'b1);
    endtask

    task automatic cycles_to_word(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bitstream_available && k < 100);
    endtask

    initial begin
        logic [23:0] w;
        int          k;
        resetn = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit = 1'b0;
        bitstream_read = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_available", bitstream_available, 1'b0);
        check("rst_bitstream", bitstream, 24'h000000);
        check("rst_busy", frame_busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_pending", commit_pending, 1'b0);
        check("rst_overrun", frame_overrun, 1'b0);

        // First tick lands FPS_DIV-1 cycles into the run, the word 3 later
        resetn = 1'b1;
        cycles_to_word(k);
        check("first_word_latency", k, 12);

        // Fill the back bank, commit mid-frame; swap happens at the next accepted tick
        bitstream_read = 1'b1;
        for (int i = 0; i < LEDCOUNT; i++) write_px(i, 24'h112233 + i * 24'h010101);
        pulse_commit();
        wait_frame();
        next_word(w);
        check("swap_word0", w, 24'h221133);
        count_to_done(k);
        check("words_per_frame", k, 11);

        // Uncommitted writes, including out-of-range addresses, leave the stream alone
        for (int i = 0; i < LEDCOUNT; i++) write_px(i, (i == 5) ? 24'hFF0000 : 24'h100000 + i);
        write_px(12, 24'hABCDEF);
        write_px(40, 24'h5A5A5A);
        wait_frame();
        for (int i = 0; i < 6; i++) next_word(w);
        check("nocommit_word5", w, 24'h271638);

        pulse_commit();
        wait_frame();
        next_word(w);
        check("commit_word0", w, 24'h001000);
        for (int i = 1; i < 6; i++) next_word(w);
        check("commit_word5", w, 24'h00FF00);

        // Stall on word 5 across several ticks, with a commit in the middle
        bitstream_read = 1'b0;
        for (int i = 0; i < 50; i++) begin
            commit = (i == 10);
            @(negedge clk);
        end
        commit = 1'b0;
        check("stall_word", bitstream, 24'h00FF00);
        check("stall_available", bitstream_available, 1'b1);
        check("stall_pending", commit_pending, 1'b1);
        bitstream_read = 1'b1;
        @(negedge clk);
        bitstream_read = 1'b0;
        next_word(w);
        check("single_advance", w, 24'h001006);
        bitstream_read = 1'b1;
        count_to_done(k);
        check("stall_tail_words", k, 5);

        // Reset at word 10 aborts the frame; the next frame restarts at index 0
        wait_frame();
        for (int i = 0; i < 11; i++) next_word(w);
        resetn = 1'b0;
        bitstream_read = 1'b0;
        @(negedge clk);
        check("abort_available", bitstream_available, 1'b0);
        check("abort_busy", frame_busy, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        cycles_to_word(k);
        check("restart_latency", k, 12);
        check("restart_word0", bitstream, 24'h001000);
        bitstream_read = 1'b1;
        count_to_done(k);
        check("restart_words", k, 11);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule
